// File: rtl/fifo_drain.sv
// Read-side FIFO consumer: pops into a 2-entry skid buffer and drives a valid/ready stream.
// Optional drained-word counter enabled by defining FIFO_DRAIN_CNT_EN.
module fifo_drain #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             fifo_empty,
  input  logic [N-1:0]     fifo_data,
  output logic             fifo_r_en,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] drain_cnt
);

  logic [1:0]   occ_q, occ_d;
  logic         inflight_q;
  logic [N-1:0] buf0_q, buf0_d;
  logic [N-1:0] buf1_q, buf1_d;
  logic         pop_out;
  logic [1:0]   level;
  logic [1:0]   wr_pos;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = buf0_q;
  assign pop_out   = out_valid & out_ready;

  always_comb begin
    // Entries held or owed after this cycle's pop; never exceeds 2, so no wrap.
    level     = occ_q + {1'b0, inflight_q} - {1'b0, pop_out};
    wr_pos    = occ_q - {1'b0, pop_out};
    fifo_r_en = arst & ~fifo_empty & (level < 2'd2);
    occ_d     = level;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    if (pop_out && (occ_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (wr_pos == 2'd0) begin
        buf0_d = fifo_data;
      end else begin
        buf1_d = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_r_en;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  occ_inv: assert property (@(posedge clk) disable iff (!arst)
    (({1'b0, occ_q} + {2'b0, inflight_q}) <= 3'd2));

`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!arst) begin
      cnt_q <= '0;
    end else if (pop_out) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign drain_cnt = cnt_q;
`else
  assign drain_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain against a behavioural FIFO with 1-cycle read latency.
module tb_fifo_drain;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             arst;
  logic             fifo_empty;
  logic [N-1:0]     fifo_data;
  logic             fifo_r_en;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] drain_cnt;

  fifo_drain #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .arst       (arst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .drain_cnt  (drain_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: only the initial block writes mem/wr_ptr, only this block pops.
  logic [N-1:0] mem [64];
  int           wr_ptr = 0;
  int           rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FIFO_DRAIN_CNT_EN
    return 32'(n % 16);
`else
    return 32'(n * 0);
`endif
  endfunction

  int reads;
  int seen;

  initial begin
    arst      = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(N'(i + 1));

    // Reset held with data available
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_r_en", 32'(fifo_r_en), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_cnt", 32'(drain_cnt), 32'd0);
    end

    // Streaming 0x01..0x08
    @(negedge clk);
    arst      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("stream_r_en", 32'(fifo_r_en), 32'(i < 8));
      check("stream_valid", 32'(out_valid), 32'(i >= 2 && i <= 9));
      if (i >= 2 && i <= 9) check("stream_data", 32'(out_data), 32'(i - 1));
      @(negedge clk);
    end
    #1;
    check("stream_cnt", 32'(drain_cnt), exp_cnt(8));

    // Back-pressure: only two reads may be issued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(N'(i + 1));
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (fifo_r_en) reads++;
      if (i >= 2) check("bp_hold_data", 32'(out_data), 32'h01);
      @(negedge clk);
    end
    #1;
    check("bp_reads", 32'(reads), 32'd2);
    check("bp_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      check("bp_drain_valid", 32'(out_valid), 32'(j < 4));
      if (j < 4) check("bp_drain_data", 32'(out_data), 32'(j + 1));
      @(negedge clk);
    end
    #1;
    check("bp_cnt", 32'(drain_cnt), exp_cnt(12));

    // Empty race: single word, FIFO empties right after the pop
    @(negedge clk);
    push(8'hA5);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("race_r_en", 32'(fifo_r_en), 32'(i == 0));
      if (out_valid) begin
        seen++;
        check("race_data", 32'(out_data), 32'hA5);
      end
      @(negedge clk);
    end
    #1;
    check("race_once", 32'(seen), 32'd1);
    check("race_cnt", 32'(drain_cnt), exp_cnt(13));

    // Mid-operation reset with one entry held and one word in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(N'(8'h31 + i));
    @(negedge clk);
    @(negedge clk);
    arst      = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_r_en", 32'(fifo_r_en), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_cnt", 32'(drain_cnt), 32'd0);
    check("mid_rst_r_en2", 32'(fifo_r_en), 32'd1);
    @(negedge clk);
    for (int i = 1; i < 6; i++) begin
      #1;
      check("mid_valid", 32'(out_valid), 32'(i == 2 || i == 3));
      if (i == 2 || i == 3) check("mid_data", 32'(out_data), 32'(8'h31 + i));
      @(negedge clk);
    end
    #1;
    check("mid_cnt", 32'(drain_cnt), exp_cnt(2));

    // Counter: 17 words after a fresh reset
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 17; i++) push(N'(8'h40 + i));
    @(negedge clk);
    arst = 1'b1;
    seen = 0;
    for (int i = 0; i < 24; i++) begin
      #1;
      if (out_valid) begin
        check("cnt_data", 32'(out_data), 32'(8'h40 + seen));
        seen++;
      end
      @(negedge clk);
    end
    #1;
    check("cnt_words", 32'(seen), 32'd17);
    check("cnt_wrap", 32'(drain_cnt), exp_cnt(17));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
